// File: rtl/mult_64bit_seq.sv
// Free-running 32x32 -> 64 shift-and-add multiplier: 34-clock passes (LOAD, 32 x ITER, DONE).
// Build option MULT_64BIT_SIGNED_EN selects a two's complement signed product.
module mult_64bit_seq (
  output logic [63:0] product,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        clk,
  input  logic        reset
);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [5:0]  cnt;

  logic [63:0] a_ext;
  logic [63:0] acc_step;

`ifdef MULT_64BIT_SIGNED_EN
  // The multiplier's top bit carries weight -2^31, so its partial product is subtracted.
  always_comb begin
    a_ext    = {{32{a[31]}}, a};
    acc_step = (cnt == 6'd31) ? (acc - mcand) : (acc + mcand);
  end
`else
  always_comb begin
    a_ext    = {32'd0, a};
    acc_step = acc + mcand;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= LOAD;
      product <= 64'd0;
      mcand   <= 64'd0;
      mplier  <= 32'd0;
      acc     <= 64'd0;
      cnt     <= 6'd0;
    end else begin
      case (state)
        LOAD: begin
          mcand  <= a_ext;
          mplier <= b;
          acc    <= 64'd0;
          cnt    <= 6'd0;
          state  <= ITER;
        end
        ITER: begin
          if (mplier[0]) acc <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) state <= DONE;
        end
        DONE: begin
          product <= acc;
          state   <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_64bit_seq.sv
// Scoreboard bench for mult_64bit_seq: stimulus pushes expected products, a monitor pops at
// each pass completion (every 34th edge after reset release) and also checks hold behaviour.
module tb_mult_64bit_seq;

  logic [63:0] product;
  logic [31:0] a, b;
  logic        clk;
  logic        reset;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          edges = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = 64'd0;

  mult_64bit_seq dut (
    .product(product),
    .a      (a),
    .b      (b),
    .clk    (clk),
    .reset  (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; a pass completes whenever this is a multiple of 34.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: product=0x%016h expected=0x%016h (edge %0d)", name, got, want, edges);
    end
  endtask

  // Monitor: result checks at pass completion, hold checks mid-pass.
  always @(negedge clk) begin
    if (!reset && edges > 0 && edges % 34 == 0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL result: no expected value queued, product=0x%016h", product);
      end else begin
        last_exp = exp_q.pop_front();
        check("result", product, last_exp);
      end
    end else if (!reset && edges % 34 == 17) begin
      check("hold", product, last_exp);
    end
  end

  task automatic wait_mod(input int m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (edges % 34 != m && n < 200);
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_mod: phase %0d not reached, edge %0d", m, edges);
    end
  endtask

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] ve;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000040A, 32'h00000462, 64'h000000000011B3D4};
`ifdef MULT_64BIT_SIGNED_EN
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vecs[3] = '{32'h80000000, 32'h00000002, 64'hFFFFFFFF00000000};
    vecs[5] = '{32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFFFFFFFFFA};
`else
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[3] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
    vecs[5] = '{32'hFFFFFFFE, 32'h00000003, 64'h00000002FFFFFFFA};
`endif
    vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000};
    vecs[4] = '{32'h00000C03, 32'h00000000, 64'h0000000000000000};

    reset = 1'b1;
    a = 32'd3;
    b = 32'd2;
    #12;
    check("reset_value", product, 64'd0);
    exp_q.push_back(64'd6);
    @(negedge clk);
    reset = 1'b0;

    // Operands changed just after LOAD of pass 0 and held: appear at end of pass 1.
    wait_mod(10);
    a = 32'h00000C03;
    b = 32'h00000702;
    wait_mod(0);
    exp_q.push_back(64'h0000000000542D06);

    // Each vector is loaded at the next LOAD edge; mid-ITER changes must be ignored.
    for (int i = 0; i < 6; i++) begin
      wait_mod(0);
      a = vecs[i].va;
      b = vecs[i].vb;
      exp_q.push_back(vecs[i].ve);
      wait_mod(10);
      a = 32'h5A5A5A5A;
      b = 32'hA5A5A5A5;
    end

    // Let the last vector complete, then reset mid-ITER at cnt = 15.
    wait_mod(0);
    a = 32'h00012345;
    b = 32'h00000007;
    wait_mod(16);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", product, 64'd0);
    exp_q.delete();
    last_exp = 64'd0;
    a = 32'd3;
    b = 32'd2;
    exp_q.push_back(64'd6);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_mod(33);
    check("pre_result_after_reset", product, 64'd0);
    wait_mod(1);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected results never checked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
